// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the asynchronous FIFO pointer stages (read and write
// sides both import this package).
//   DEFAULT_ADDR_WIDTH : default memory address width
//   PTR_WIDTH          : pointer width for the default build (address + wrap bit)
//   bin2gray/gray2bin  : code conversions on a 32-bit container; callers
//                        zero-extend narrower pointers and truncate the result.
//                        Leading zeros do not disturb either conversion.
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 7;
    localparam int PTR_WIDTH          = DEFAULT_ADDR_WIDTH + 1;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return (b >> 1) ^ b;
    endfunction

    // Prefix XOR from the MSB down.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/pointer_sync.sv
// ---------------------------------------------------------------------------
// pointer_sync
// Multi-flop clock-domain-crossing synchronizer for a Gray-coded pointer.
// Pure flop chain: nothing combinational between stages.
// Ports:
//   clk_i : destination-domain clock
//   rst_i : asynchronous active-high reset, clears every stage
//   d_i   : Gray pointer from the source domain
//   q_o   : synchronized pointer (last stage)
// ---------------------------------------------------------------------------
module pointer_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/read_pointer_empty.sv
// ---------------------------------------------------------------------------
// read_pointer_empty
// Read-domain pointer / empty-flag stage of the asynchronous FIFO.
// Synchronizes the write Gray pointer into clock_read, keeps the binary and
// Gray read pointers, and produces registered empty / almost_empty / level.
// Optional feature macro: READ_UNDERFLOW_FLAG_EN (sticky underflow flop).
// Ports:
//   clock_read    : read-domain clock
//   read_reset    : asynchronous active-high reset
//   read_enable   : pop request (ignored while empty)
//   write_pointer : Gray write pointer from the write domain (asynchronous)
//   read_address  : binary memory read address
//   read_pointer  : registered Gray read pointer for the write-side sync
//   empty         : registered empty flag
//   almost_empty  : registered, level <= ALMOST_EMPTY_THRESHOLD
//   read_level    : registered fill level (pessimistic)
//   underflow     : sticky pop-while-empty flag, constant 0 when disabled
// ---------------------------------------------------------------------------
module read_pointer_empty
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH             = DEFAULT_ADDR_WIDTH,
    parameter int SYNC_STAGES            = 2,
    parameter int ALMOST_EMPTY_THRESHOLD = 4
) (
    input  logic                  clock_read,
    input  logic                  read_reset,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH:0]   write_pointer,
    output logic [ADDR_WIDTH-1:0] read_address,
    output logic [ADDR_WIDTH:0]   read_pointer,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   read_level,
    output logic                  underflow
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] AE_THR = PTR_W'(ALMOST_EMPTY_THRESHOLD);

    logic [PTR_W-1:0] read_binary_q, read_binary_d;
    logic [PTR_W-1:0] read_gray_q,   read_gray_d;
    logic [PTR_W-1:0] level_q,       level_d;
    logic             empty_q,       empty_d;
    logic             almost_empty_q, almost_empty_d;
    logic [PTR_W-1:0] sync_write_pointer;
    logic [PTR_W-1:0] sync_write_binary;
    logic             pop;

    pointer_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (PTR_W)
    ) u_wptr_sync (
        .clk_i  (clock_read),
        .rst_i  (read_reset),
        .d_i    (write_pointer),
        .q_o    (sync_write_pointer)
    );

    always_comb begin
        pop               = read_enable & ~empty_q;
        read_binary_d     = read_binary_q + {{ADDR_WIDTH{1'b0}}, pop};
        read_gray_d       = PTR_W'(bin2gray(32'(read_binary_d)));
        sync_write_binary = PTR_W'(gray2bin(32'(sync_write_pointer)));
        // Empty compares the post-pop pointer so popping the last word sets
        // empty on the same edge, not one cycle later.
        empty_d           = (read_gray_d == sync_write_pointer);
        // Uses the synchronized (lagging) write pointer, so it never
        // overstates occupancy; equal pointers give level 0, keeping
        // empty/level/almost_empty consistent.
        level_d           = sync_write_binary - read_binary_d;
        almost_empty_d    = (level_d <= AE_THR);
    end

    always_ff @(posedge clock_read or posedge read_reset) begin
        if (read_reset) begin
            read_binary_q  <= '0;
            read_gray_q    <= '0;
            level_q        <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
        end else begin
            read_binary_q  <= read_binary_d;
            read_gray_q    <= read_gray_d;
            level_q        <= level_d;
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
        end
    end

`ifdef READ_UNDERFLOW_FLAG_EN
    logic underflow_q;

    always_ff @(posedge clock_read or posedge read_reset) begin
        if (read_reset) begin
            underflow_q <= 1'b0;
        end else if (read_enable && empty_q) begin
            underflow_q <= 1'b1;
        end
    end

    assign underflow = underflow_q;
`else
    assign underflow = 1'b0;
`endif

    assign read_address = read_binary_q[ADDR_WIDTH-1:0];
    assign read_pointer = read_gray_q;
    assign empty        = empty_q;
    assign almost_empty = almost_empty_q;
    assign read_level   = level_q;

endmodule

// File: tb/tb_read_pointer_empty.sv
// ---------------------------------------------------------------------------
// tb_read_pointer_empty
// Directed phases plus a random phase. The reference model keeps plain
// integer counts of words written and read; the synchronizer is modelled as
// a history of the write count delayed by SYNC cycles.
// ---------------------------------------------------------------------------
module tb_read_pointer_empty;

    localparam int AW   = 7;
    localparam int SYNC = 2;
    localparam int THR  = 4;
    localparam int DEPTH = 1 << AW;

    logic          clock_read;
    logic          read_reset;
    logic          read_enable;
    logic [AW:0]   write_pointer;
    logic [AW-1:0] read_address;
    logic [AW:0]   read_pointer;
    logic          empty;
    logic          almost_empty;
    logic [AW:0]   read_level;
    logic          underflow;

    int vectors;
    int miscompares;

    // reference model state
    int wcnt;          // words written so far (unbounded)
    int rcnt;          // words read so far (unbounded)
    int whist[$];      // write count driven at each edge
    bit exp_empty;
    bit exp_uf;
    int exp_level;

    read_pointer_empty #(
        .ADDR_WIDTH             (AW),
        .SYNC_STAGES            (SYNC),
        .ALMOST_EMPTY_THRESHOLD (THR)
    ) dut (
        .clock_read    (clock_read),
        .read_reset    (read_reset),
        .read_enable   (read_enable),
        .write_pointer (write_pointer),
        .read_address  (read_address),
        .read_pointer  (read_pointer),
        .empty         (empty),
        .almost_empty  (almost_empty),
        .read_level    (read_level),
        .underflow     (underflow)
    );

    // clock / reset
    initial clock_read = 1'b0;
    always #5 clock_read = ~clock_read;

    function automatic logic [AW:0] gray_of(input int n);
        logic [AW:0] b;
        b = AW'(0);
        b = (AW+1)'(n % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        wcnt      = 0;
        rcnt      = 0;
        exp_empty = 1'b1;
        exp_uf    = 1'b0;
        exp_level = 0;
        whist.delete();
        for (int i = 0; i < SYNC; i++) whist.push_back(0);
    endtask

    task automatic check_all();
        chk("read_address", 32'(read_address), 32'(rcnt % DEPTH));
        chk("read_pointer", 32'(read_pointer), 32'(gray_of(rcnt)));
        chk("empty",        32'(empty),        32'(exp_empty));
        chk("almost_empty", 32'(almost_empty), 32'(exp_level <= THR));
        chk("read_level",   32'(read_level),   32'(exp_level));
        chk("underflow",    32'(underflow),    32'(exp_uf));
    endtask

    // One read clock: drive inputs, advance the model at the edge, check #1 later.
    task automatic tick(input bit ren);
        int vis;
        bit was_empty;
        read_enable   = ren;
        write_pointer = gray_of(wcnt);
        @(posedge clock_read);
        whist.push_back(wcnt);
        vis = whist[whist.size() - 1 - SYNC];
        while (whist.size() > SYNC + 1) void'(whist.pop_front());
        was_empty = exp_empty;
        if (ren && !was_empty) rcnt++;
`ifdef READ_UNDERFLOW_FLAG_EN
        if (ren && was_empty) exp_uf = 1'b1;
`endif
        exp_level = vis - rcnt;
        exp_empty = (exp_level == 0);
        #1;
        check_all();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear with no edge.
    task automatic async_reset();
        #2;
        read_reset = 1'b1;
        #1;
        chk("rst_read_pointer", 32'(read_pointer), 32'd0);
        chk("rst_read_address", 32'(read_address), 32'd0);
        chk("rst_empty",        32'(empty),        32'd1);
        chk("rst_read_level",   32'(read_level),   32'd0);
        chk("rst_almost_empty", 32'(almost_empty), 32'd1);
        chk("rst_underflow",    32'(underflow),    32'd0);
        read_enable   = 1'b0;
        write_pointer = '0;
        model_reset();
        @(posedge clock_read);
        @(negedge clock_read);
        read_reset = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        read_enable   = 1'b0;
        write_pointer = '0;
        read_reset    = 1'b1;
        model_reset();
        #1;
        chk("init_empty",        32'(empty),        32'd1);
        chk("init_almost_empty", 32'(almost_empty), 32'd1);
        chk("init_read_level",   32'(read_level),   32'd0);
        @(posedge clock_read);
        @(negedge clock_read);
        read_reset = 1'b0;
        tick(0);
        tick(0);

        // Single write: empty falls exactly SYNC+1 clocks after the change.
        wcnt = 1;
        tick(0);
        tick(0);
        chk("single_empty_c2", 32'(empty), 32'd1);
        tick(0);
        chk("single_empty_c3", 32'(empty), 32'd0);
        chk("single_level",    32'(read_level), 32'd1);
        tick(1);
        chk("single_addr",     32'(read_address), 32'd1);
        chk("single_empty_pop", 32'(empty), 32'd1);
        tick(0);

        // Underflow: read_enable held while empty, pointers hold.
        for (int i = 0; i < 5; i++) tick(1);
        chk("uf_addr_hold", 32'(read_address), 32'd1);
        tick(0);

        // Fill, partially drain to 37, then reset mid-stream.
        async_reset();
        wcnt = DEPTH;
        for (int i = 0; i < SYNC + 1; i++) tick(0);
        chk("full_level", 32'(read_level), 32'(DEPTH));
        chk("full_ae",    32'(almost_empty), 32'd0);
        for (int i = 0; i < 37; i++) tick(1);
        chk("pre_rst_addr", 32'(read_address), 32'd37);
        async_reset();

        // Fill then full drain.
        tick(0);
        wcnt = DEPTH;
        for (int i = 0; i < SYNC + 1; i++) tick(0);
        for (int i = 0; i < DEPTH; i++) tick(1);
        chk("drain_empty",   32'(empty), 32'd1);
        chk("drain_pointer", 32'(read_pointer), 32'h0C0);
        tick(1);

        // Wrap: write/read pairs, level stays small.
        for (int i = 0; i < 300; i++) begin
            wcnt++;
            tick(1);
            vectors++;
            assert (read_level <= 2)
            else begin
                miscompares++;
                $error("FAIL wrap_level_bound: observed %0d expected <=2", read_level);
            end
        end
        for (int i = 0; i < SYNC + 2; i++) tick(1);
        chk("wrap_empty", 32'(empty), 32'd1);

        // Simultaneous pop and write at level 4.
        for (int i = 0; i < 4; i++) begin
            wcnt++;
            tick(0);
        end
        for (int i = 0; i < SYNC + 1; i++) tick(0);
        chk("sim_level_pre", 32'(read_level), 32'd4);
        wcnt++;
        tick(1);
        for (int i = 0; i < SYNC; i++) tick(0);
        chk("sim_level_post", 32'(read_level), 32'd4);
        chk("sim_ae_post",    32'(almost_empty), 32'd1);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) < 45 && (wcnt - rcnt) < DEPTH) wcnt++;
            tick(1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 200; i++) tick(1);
        chk("final_empty", 32'(empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
